// File: rtl/accel_sort_blk.sv
`default_nettype none
// ============================================================================
// Module   : accel_sort_blk
// Purpose  : Block-sort accelerator. Keystream-XOR decrypt, insertion sort into
//            a DEPTH-entry register array, then sorted drain with backpressure.
//            Optional decrypt path: define ACCEL_SORT_BLK_DECRYPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module accel_sort_blk #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] key_data,
  input  logic                  key_valid,
  output logic                  key_pull,
  input  logic                  no_compare,
  input  logic                  descending,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_last_idx = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_s      [DEPTH];
  logic [DATA_WIDTH-1:0] w_next_s [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_pos;
  logic                  r_nocmp;
  logic                  r_desc;
  logic                  r_out_valid;
  logic                  w_nocmp;
  logic                  w_desc;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_value;

  assign w_ready = (r_state == S_FILL);
  assign w_pop   = (r_state == S_DRAIN) && out_ready;

`ifdef ACCEL_SORT_BLK_DECRYPT_EN
  assign w_value  = in_data ^ key_data;
  assign w_accept = in_valid && key_valid && w_ready;
  assign key_pull = w_accept;
`else
  logic w_unused_key;
  assign w_unused_key = ^{key_valid, key_data};
  assign w_value      = in_data;
  assign w_accept     = in_valid && w_ready;
  assign key_pull     = 1'b0;
`endif

  // The first record of a block sees the live mode pins; later ones the latched copy.
  assign w_nocmp = (r_count == '0) ? no_compare : r_nocmp;
  assign w_desc  = (r_count == '0) ? descending : r_desc;

  // Array is always sorted, so the count of entries ordered before v is its slot.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_WIDTH'(i) < r_count) &&
          (w_desc ? (r_s[i] >= w_value) : (r_s[i] <= w_value)))
        w_pos = w_pos + c_one;
    end
    if (w_nocmp)
      w_pos = r_count;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next_s[i] = r_s[i];
      if (w_accept) begin
        if (CNT_WIDTH'(i) == w_pos)
          w_next_s[i] = w_value;
        else if ((CNT_WIDTH'(i) > w_pos) && (CNT_WIDTH'(i) <= r_count))
          w_next_s[i] = r_s[(i > 0) ? i - 1 : 0];
      end else if (w_pop && (i < DEPTH - 1)) begin
        w_next_s[i] = r_s[(i < DEPTH - 1) ? i + 1 : i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_count     <= '0;
      r_nocmp     <= 1'b0;
      r_desc      <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_s[i] <= '0;
    end else begin
      r_s <= w_next_s;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_count <= r_count + c_one;
            if (r_count == '0) begin
              r_nocmp <= no_compare;
              r_desc  <= descending;
            end
            if ((r_count == c_last_idx) || in_last) begin
              r_state     <= S_DRAIN;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_count <= r_count - c_one;
            if (r_count == c_one) begin
              r_state     <= S_FILL;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_FILL;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_s[0];
  assign busy      = (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_accel_sort_blk.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_sort_blk
// Purpose  : Directed self-checking bench for accel_sort_blk (DEPTH=4, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accel_sort_blk;

  localparam int DW  = 16;
  localparam int DEP = 4;
  localparam int CW  = 3;
`ifdef ACCEL_SORT_BLK_DECRYPT_EN
  localparam logic [DW-1:0] c_key = 16'hFFFF;
`else
  localparam logic [DW-1:0] c_key = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] key_data;
  logic          key_valid;
  logic          key_pull;
  logic          no_compare;
  logic          descending;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  accel_sort_blk #(.DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .key_data(key_data), .key_valid(key_valid), .key_pull(key_pull),
    .no_compare(no_compare), .descending(descending),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Presents one record for one cycle; reports whether key_pull fired with it.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic kv,
                      input logic [DW-1:0] key, output logic pulled);
    in_data   = d;
    in_last   = last;
    key_valid = kv;
    key_data  = key;
    in_valid  = 1'b1;
    #1;
    pulled = key_pull;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    key_data = '0; key_valid = 1'b0; no_compare = 1'b0; descending = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || key_pull !== 1'b0 ||
        busy !== 1'b0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b ov=%b kp=%b busy=%b od=%h, need 1 0 0 0 0000",
               in_ready, out_valid, key_pull, busy, out_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b busy=%b, need 1 0", in_ready, busy);
    end
  endtask

  task automatic test_ascending();
    logic [DW-1:0] din [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic [DW-1:0] exp [4] = '{16'd1, 16'd3, 16'd7, 16'd9};
    logic p;
    for (int k = 0; k < 4; k++) begin
      send(din[k] ^ c_key, 1'b0, 1'b1, c_key, p);
      if (k == 0) begin
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL asc_busy: busy=%b ov=%b, need 1 0", busy, out_valid);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL asc_out[%0d]: ov=%b od=%0d rdy=%b, need ov=1 od=%0d rdy=0",
                 k, out_valid, out_data, in_ready, exp[k]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL asc_done: rdy=%b ov=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
    end
  endtask

`ifdef ACCEL_SORT_BLK_DECRYPT_EN
  task automatic test_decrypt();
    logic [DW-1:0] din [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic [DW-1:0] exp [4] = '{16'd1, 16'd3, 16'd7, 16'd9};
    logic p;
    int   pulls = 0;
    for (int k = 0; k < 4; k++) begin
      send(~din[k], 1'b0, 1'b1, 16'hFFFF, p);
      if (p) pulls++;
    end
    n_cmp++;
    if (pulls !== 4) begin
      n_bad++;
      $display("FAIL dec_pulls: key_pull pulses=%0d, need 4", pulls);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp[k] || key_pull !== 1'b0) begin
        n_bad++;
        $display("FAIL dec_out[%0d]: ov=%b od=%0d kp=%b, need ov=1 od=%0d kp=0",
                 k, out_valid, out_data, key_pull, exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_key_ignored();
    logic [DW-1:0] din [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic [DW-1:0] exp [4] = '{16'd1, 16'd3, 16'd7, 16'd9};
    logic p;
    int   pulls = 0;
    for (int k = 0; k < 4; k++) begin
      send(din[k], 1'b0, 1'b0, 16'hFFFF, p);
      if (p) pulls++;
    end
    n_cmp++;
    if (pulls !== 0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL nokey_accept: pulls=%0d ov=%b, need 0 1", pulls, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        n_bad++;
        $display("FAIL nokey_out[%0d]: ov=%b od=%0d, need ov=1 od=%0d",
                 k, out_valid, out_data, exp[k]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_modes();
    logic [DW-1:0] din  [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic [DW-1:0] expn [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic [DW-1:0] expd [4] = '{16'd9, 16'd7, 16'd3, 16'd1};
    logic p;
    // Arrival order, with sort-mode pins flipped after the first record.
    for (int k = 0; k < 4; k++) begin
      no_compare = (k == 0);
      descending = (k != 0);
      send(din[k] ^ c_key, 1'b0, 1'b1, c_key, p);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== expn[k]) begin
        n_bad++;
        $display("FAIL nocmp_out[%0d]: ov=%b od=%0d, need ov=1 od=%0d",
                 k, out_valid, out_data, expn[k]);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      descending = (k == 0);
      no_compare = (k != 0);
      send(din[k] ^ c_key, 1'b0, 1'b1, c_key, p);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== expd[k]) begin
        n_bad++;
        $display("FAIL desc_out[%0d]: ov=%b od=%0d, need ov=1 od=%0d",
                 k, out_valid, out_data, expd[k]);
      end
      @(posedge clk); #1;
    end
    no_compare = 1'b0;
    descending = 1'b0;
  endtask

  task automatic test_short_block();
    logic p;
    send(16'd5 ^ c_key, 1'b0, 1'b1, c_key, p);
    send(16'd2 ^ c_key, 1'b1, 1'b1, c_key, p);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'd2 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL short_out0: ov=%b od=%0d rdy=%b, need 1 2 0", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'd5) begin
      n_bad++;
      $display("FAIL short_out1: ov=%b od=%0d, need 1 5", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL short_done: rdy=%b ov=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_stalls();
    logic [DW-1:0] exp [3] = '{16'd1, 16'd4, 16'd4};
    logic p;
`ifdef ACCEL_SORT_BLK_DECRYPT_EN
    in_data = 16'd4 ^ c_key; key_data = c_key; in_valid = 1'b1; key_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (key_pull !== 1'b0) begin
        n_bad++;
        $display("FAIL keystall_pull[%0d]: kp=%b, need 0", k, key_pull);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL keystall_busy[%0d]: busy=%b, need 0", k, busy);
      end
    end
    in_valid = 1'b0;
`endif
    send(16'd4 ^ c_key, 1'b0, 1'b1, c_key, p);
    send(16'd1 ^ c_key, 1'b0, 1'b1, c_key, p);
    send(16'd4 ^ c_key, 1'b1, 1'b1, c_key, p);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 16'd1) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: ov=%b od=%0d, need 1 1", k, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        n_bad++;
        $display("FAIL dup_out[%0d]: ov=%b od=%0d, need ov=1 od=%0d",
                 k, out_valid, out_data, exp[k]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_done: rdy=%b busy=%b, need 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [DW-1:0] din [4] = '{16'd7, 16'd3, 16'd9, 16'd1};
    logic p;
    for (int k = 0; k < 4; k++)
      send(din[k] ^ c_key, 1'b0, 1'b1, c_key, p);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL rst_drain: ov=%b rdy=%b busy=%b od=%0d, need 0 1 0 0",
               out_valid, in_ready, busy, out_data);
    end
    reset = 1'b0;
    send(16'd8 ^ c_key, 1'b0, 1'b1, c_key, p);
    send(16'd6 ^ c_key, 1'b1, 1'b1, c_key, p);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'd6) begin
      n_bad++;
      $display("FAIL rst_new0: ov=%b od=%0d, need 1 6", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 16'd8) begin
      n_bad++;
      $display("FAIL rst_new1: ov=%b od=%0d, need 1 8", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_new_done: ov=%b rdy=%b, need 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
`ifdef ACCEL_SORT_BLK_DECRYPT_EN
    test_decrypt();
`else
    test_key_ignored();
`endif
    test_modes();
    test_short_block();
    test_stalls();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accel_sort_blk.md
# accel_sort_blk

Parametrised block-sort accelerator for the encrypt/sort PLB core. Records arrive over a valid/ready stream and are XOR-decrypted against a keystream, then sorted by insertion into a DEPTH-entry register array. Each completed block is streamed out in sorted order. It generalises the fixed 4-record sort stage to any block depth and record width, and adds descending order, short (last) blocks, output backpressure and a bypass ordering mode.

## Interface
- `DATA_WIDTH`, default 128: record and keystream width in bits.
- `DEPTH`, default 8: records per block. Must be ≥2.
- `CNT_WIDTH`, default 4: entry-count width. Must satisfy 2^CNT_WIDTH > DEPTH.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in DATA_WIDTH: encrypted record.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: this record closes the current block early.
- `in_ready` out 1: block can accept a record.
- `key_data` in DATA_WIDTH: keystream word.
- `key_valid` in 1: `key_data` is valid.
- `key_pull` out 1: pops the keystream word in the same cycle it is used.
- `no_compare` in 1: records leave in arrival order (encryption pass).
- `descending` in 1: sort largest-first.
- `out_data` out DATA_WIDTH: decrypted, ordered record.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `busy` out 1: block holds data (count ≠ 0).

## Operation
- The register array `s[0..DEPTH-1]` holds `count` valid entries. It is kept sorted at all times, and `s[0]` is the next output.
- **FILL state**
  - `in_ready = 1` while in FILL.
  - Accept occurs when `in_valid & key_valid & in_ready`. On accept, `key_pull = 1` combinationally and `v = in_data ^ key_data`.
  - Ascending insert: p = number of valid entries ≤ v.
  - Descending insert: p = number of valid entries ≥ v.
  - Entries at indices p..count-1 shift up one place, `s[p] = v`, and `count` increments.
  - No-compare mode: p = count, i.e. append.
  - All comparisons are unsigned and span the full DATA_WIDTH.
- **Mode latching**
  - `no_compare` and `descending` are sampled on the first accept of each block (count = 0).
  - The sampled values are held until the block drains; mid-block changes are ignored.
- **FILL → DRAIN** on an accept that makes count = DEPTH, or on any accept with `in_last = 1`.
  - A block therefore always contains 1..DEPTH records.
  - `in_last` is ignored when `in_valid` is low.
- **DRAIN state**
  - `in_ready = 0`, `out_valid = 1`, `out_data = s[0]`.
  - On `out_ready`: the array shifts down one place and count decrements.
  - When count reaches 0, go to FILL.
- If `key_valid` is low, nothing is accepted and `key_pull` stays 0.
- Unused array entries are don't-care but must never reach `out_data` while `out_valid = 1`.

## Timing
- Reset values: state FILL, count 0, `in_ready` 1, `out_valid` 0, `key_pull` 0, `busy` 0, `out_data` 0, latched modes 0.
- Sustained rate: one record accepted per cycle in FILL, one record emitted per cycle in DRAIN with `out_ready` held high.
- Latency: the final accept of a block at cycle N gives `out_valid = 1` at cycle N+1.
- A block of K records occupies the core for K FILL cycles plus K DRAIN cycles (minimum). There is no fill/drain overlap.
- After the final output handshake at cycle M, `in_ready = 1` at cycle M+1.
- `out_data` and `out_valid` are registered. `in_ready` is decoded from state only. `key_pull` is the only combinational output.
- Backpressure: while `out_ready = 0`, `out_data` and `out_valid` hold stable.
- Reset mid-block or mid-drain: the next edge discards the contents and returns to reset values. No partial output follows.

## Configuration
- `ACCEL_SORT_BLK_DECRYPT_EN` defined:
  - `v = in_data ^ key_data`.
  - Accepts require `key_valid`.
  - `key_pull` behaves as described above.
- `ACCEL_SORT_BLK_DECRYPT_EN` undefined:
  - `v = in_data`.
  - `key_valid` and `key_data` are ignored, and `key_pull` is tied to 0.
  - Accepts require only `in_valid & in_ready`.

## Test plan
- **Ascending full block:** DEPTH=4, key 0, inputs 7,3,9,1 → outputs 1,3,7,9 on 4 consecutive cycles. `in_ready` is low exactly 4 cycles.
- **Decrypt:** with the macro defined and key word 0xFF..FF, inputs ~7,~3,~9,~1 → outputs 1,3,7,9. `key_pull` pulses exactly 4 times.
- **Modes:**
  - `no_compare = 1`: inputs 7,3,9,1 → 7,3,9,1.
  - `descending = 1`: same inputs → 9,7,3,1.
  - Toggling either input mid-block has no effect.
- **Short block:** inputs 5 then 2 with `in_last` → outputs 2,5. Then FILL resumes with count 0 and `busy` drops.
- **Stalls:**
  - `key_valid` low for 3 cycles delays the accept and holds `key_pull` at 0.
  - `out_ready` low for 5 cycles holds `out_data = 1` stable.
  - Duplicate inputs 4,4 → 4,4.
- **Reset mid-drain:** assert `reset` after 2 of 4 outputs → next cycle `out_valid = 0`, `in_ready = 1`. A new block 8,6 sorts to 6,8.
